// File: rtl/icap_reboot_seq.sv
// rtl/icap_reboot_seq.sv - Wishbone master sequencing a Spartan-6 IPROG multiboot through the ICAP slave
module icap_reboot_seq #(
   parameter int         GAP_CYCLES = 16,
   parameter int         TIMEOUT    = 255,
   parameter logic [7:0] OPCODE     = 8'h0B
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [23:0] boot_addr,
   input  logic [23:0] golden_addr,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_dat_o,
   input  logic        wb_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STROBE,
      S_GAP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [23:0] boot_q, boot_d;
   logic [23:0] gold_q, gold_d;
   logic        busy_d, done_d, error_d, stb_d;
   logic [15:0] word_d;

   // IPROG command stream: sync, WBSTAR/GENERAL1..4, CMD=IPROG, NOP padding
   function automatic logic [15:0] cmd_word(input logic [3:0]  idx,
                                            input logic [23:0] b,
                                            input logic [23:0] g);
      logic [15:0] w;
      case (idx)
         4'd0:    w = 16'hFFFF;
         4'd1:    w = 16'hAA99;
         4'd2:    w = 16'h5566;
         4'd3:    w = 16'h3261;
         4'd4:    w = b[15:0];
         4'd5:    w = 16'h3281;
         4'd6:    w = {OPCODE, b[23:16]};
         4'd7:    w = 16'h32A1;
         4'd8:    w = g[15:0];
         4'd9:    w = 16'h32C1;
         4'd10:   w = {OPCODE, g[23:16]};
         4'd11:   w = 16'h30A1;
         4'd12:   w = 16'h000E;
         default: w = 16'h2000;
      endcase
      return w;
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      boot_d  = boot_q;
      gold_d  = gold_q;
      busy_d  = busy;
      done_d  = 1'b0;
      error_d = 1'b0;
      stb_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // a start coinciding with the done/error pulse is dropped
            if (start && !done && !error) begin
               boot_d  = boot_addr;
               gold_d  = golden_addr;
               idx_d   = 4'd0;
               cnt_d   = 16'd0;
               busy_d  = 1'b1;
               stb_d   = 1'b1;
               state_d = S_STROBE;
            end
         end
         S_STROBE: begin
            if (wb_ack_i) begin
               cnt_d   = 16'd0;
               state_d = S_GAP;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               cnt_d   = 16'd0;
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
               stb_d = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == 16'(GAP_CYCLES - 1)) begin
               cnt_d = 16'd0;
               if (idx_q == 4'd15) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  stb_d   = 1'b1;
                  state_d = S_STROBE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
      word_d = cmd_word(idx_d, boot_d, gold_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         idx_q    <= 4'd0;
         cnt_q    <= 16'd0;
         boot_q   <= 24'd0;
         gold_q   <= 24'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_dat_o <= 32'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         boot_q   <= boot_d;
         gold_q   <= gold_d;
         busy     <= busy_d;
         done     <= done_d;
         error    <= error_d;
         wb_cyc_o <= stb_d;
         wb_stb_o <= stb_d;
         wb_we_o  <= stb_d;
         wb_dat_o <= stb_d ? {16'h0000, word_d} : 32'd0;
      end
   end

endmodule
